// File: rtl/turfio_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// turfio_pkg
// Shared definitions for the SURF->TURFIO transmit framer and its helpers:
// default training/idle words, counter width, link state and byte index types.
// No ports (package).
// -----------------------------------------------------------------------------
package turfio_pkg;

  // Non-rotationally-symmetric so the far end can find bit and byte alignment.
  localparam logic [31:0] TRAIN_PATTERN_DEF = 32'hA55A6996;
  localparam logic [31:0] IDLE_WORD_DEF     = 32'h00000000;
  localparam int          CNT_WIDTH_DEF     = 16;

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } link_state_t;

  typedef logic [1:0] byte_idx_t;

  // Byte slot during which the next word is chosen and loaded.
  localparam byte_idx_t LAST_BYTE = 2'd3;

  // Byte that leaves the serializer first (MSB byte of the word).
  function automatic logic [7:0] msb_byte(input logic [31:0] word);
    return word[31:24];
  endfunction

endpackage

// File: rtl/turfio_tx_framer_if.sv
// -----------------------------------------------------------------------------
// turfio_tx_framer_if
// Word stream into the transmit framer (valid/ready, 32-bit data).
//   s_tdata  : data word, sampled only when s_tvalid & s_tready
//   s_tvalid : source has a word
//   s_tready : framer takes the word this clock
// master = the word source, slave = the framer.
// -----------------------------------------------------------------------------
interface turfio_tx_framer_if;
  import turfio_pkg::*;

  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready
  );

endinterface

// File: rtl/turfio_tx_framer_sat_counter.sv
// -----------------------------------------------------------------------------
// turfio_sat_counter
// Saturating up-counter with clear and enable. Clear wins over a coincident
// increment; the count sticks at all-ones.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (count -> 0)
//   clr_i   : clear count to 0
//   en_i    : increment by one
//   count_o : current count
// -----------------------------------------------------------------------------
module turfio_sat_counter
  import turfio_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_count;

  // Count register: reset, clear, saturating increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/turfio_tx_framer.sv
// -----------------------------------------------------------------------------
// turfio_tx_framer
// SURF-side transmit framer. Takes 32-bit words from a valid/ready stream and
// emits one byte per clock (MSB byte first) to an 8:1 OSERDES. Sends a
// training pattern while train_i is high and an idle word when no data is
// offered. Words are chosen only at the byte-3 boundary, so a word is never
// truncated except by reset.
//   clk_i          : RXCLK-domain clock
//   rst_i          : synchronous active-high reset
//   train_i        : level, forces the training pattern (at next boundary)
//   s_axis         : word stream (slave side)
//   oserdes_data_o : byte to OSERDES, bit 7 first
//   frame_o        : high on byte 0 of every word
//   is_data_o      : high for all 4 bytes of an accepted data word
//   word_count_o   : saturating count of data words accepted
//   count_clr_i    : clears word_count_o (wins over an increment)
// -----------------------------------------------------------------------------
module turfio_tx_framer
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter logic [31:0] IDLE_WORD     = IDLE_WORD_DEF,
  parameter int          CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 train_i,
  turfio_tx_framer_if.slave    s_axis,
  output logic [7:0]           oserdes_data_o,
  output logic                 frame_o,
  output logic                 is_data_o,
  output logic [CNT_WIDTH-1:0] word_count_o,
  input  logic                 count_clr_i
);

  link_state_t r_state;
  link_state_t w_state_nxt;
  byte_idx_t   r_byte_cnt;
  logic [23:0] r_shreg;      // bytes 1..3 of the word currently on the wire
  logic [7:0]  r_data;
  logic        r_frame;
  logic        r_is_data;
  logic        w_boundary;
  logic        w_handshake;
  logic        w_is_data_nxt;
  logic [31:0] w_word_nxt;

  assign w_boundary = (r_byte_cnt == LAST_BYTE);

  // Ready only in RUN at the boundary; the TRAIN->RUN boundary never takes
  // data, so the first word after training is always an idle word.
  assign s_axis.s_tready = (r_state == RUN) & w_boundary & ~train_i;
  assign w_handshake     = s_axis.s_tready & s_axis.s_tvalid;

  // Link state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= TRAIN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next word, decided only at the boundary.
  always_comb begin
    w_state_nxt   = r_state;
    w_word_nxt    = IDLE_WORD;
    w_is_data_nxt = 1'b0;
    if (w_boundary) begin
      case (r_state)
        TRAIN: begin
          if (train_i) begin
            w_word_nxt = TRAIN_PATTERN;
          end else begin
            w_state_nxt = RUN;
            w_word_nxt  = IDLE_WORD;
          end
        end
        RUN: begin
          if (train_i) begin
            w_state_nxt = TRAIN;
            w_word_nxt  = TRAIN_PATTERN;
          end else if (w_handshake) begin
            w_word_nxt    = s_axis.s_tdata;
            w_is_data_nxt = 1'b1;
          end else begin
            w_word_nxt = IDLE_WORD;
          end
        end
        default: begin
          w_state_nxt = TRAIN;
          w_word_nxt  = TRAIN_PATTERN;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Byte counter, shift register and registered byte/frame/data-flag outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_byte_cnt <= 2'd0;
      r_shreg    <= 24'h000000;
      r_data     <= 8'h00;
      r_frame    <= 1'b0;
      r_is_data  <= 1'b0;
    end else begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      if (w_boundary) begin
        r_data    <= msb_byte(w_word_nxt);
        r_shreg   <= w_word_nxt[23:0];
        r_frame   <= 1'b1;
        r_is_data <= w_is_data_nxt;
      end else begin
        r_data    <= r_shreg[23:16];
        r_shreg   <= {r_shreg[15:0], 8'h00};
        r_frame   <= 1'b0;
        r_is_data <= r_is_data;
      end
    end
  end

  assign oserdes_data_o = r_data;
  assign frame_o        = r_frame;
  assign is_data_o      = r_is_data;

  turfio_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_word_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (count_clr_i),
    .en_i    (w_handshake),
    .count_o (word_count_o)
  );

endmodule

// File: tb/tb_turfio_tx_framer.sv
// -----------------------------------------------------------------------------
// Testbench for turfio_tx_framer. Two instances share all stimulus: one with
// the default 16-bit counter, one with a 2-bit counter so saturation and
// clear-vs-increment can be reached in a few words. Expected bytes come from a
// queue filled with four byte entries per word as the link rules pick words.
// -----------------------------------------------------------------------------
module tb_turfio_tx_framer;
  import turfio_pkg::*;

  logic clk = 1'b0;
  logic rst, train, clr;

  turfio_tx_framer_if if_a ();
  turfio_tx_framer_if if_b ();
  assign if_b.s_tdata  = if_a.s_tdata;
  assign if_b.s_tvalid = if_a.s_tvalid;

  logic [7:0]  data_a, data_b;
  logic        frame_a, frame_b, isd_a, isd_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  turfio_tx_framer dut_a (
    .clk_i(clk), .rst_i(rst), .train_i(train), .s_axis(if_a),
    .oserdes_data_o(data_a), .frame_o(frame_a), .is_data_o(isd_a),
    .word_count_o(cnt_a), .count_clr_i(clr)
  );

  turfio_tx_framer #(.CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .train_i(train), .s_axis(if_b),
    .oserdes_data_o(data_b), .frame_o(frame_b), .is_data_o(isd_b),
    .word_count_o(cnt_b), .count_clr_i(clr)
  );

  always #4 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  int          m_cyc;        // clocks since reset release
  bit          m_training;
  logic [9:0]  m_q[$];       // {byte, frame, is_data}
  int          m_cnt, m_cnt2;
  logic [7:0]  e_data;
  logic        e_frame, e_isdata;
  bit          last_hs;

  wire [39:0] got = {data_a, frame_a, isd_a, if_a.s_tready, cnt_a, cnt_b,
                     data_b, frame_b, isd_b, if_b.s_tready};

  function automatic logic exp_ready();
    return (!m_training && (m_cyc % 4 == 3) && !train);
  endfunction

  function automatic logic [39:0] exp_vec();
    logic [15:0] c1;
    logic [1:0]  c2;
    c1 = m_cnt[15:0];
    c2 = m_cnt2[1:0];
    return {e_data, e_frame, e_isdata, exp_ready(), c1, c2,
            e_data, e_frame, e_isdata, exp_ready()};
  endfunction

  // Advance the model by one clock using current inputs, then clock the DUTs.
  task automatic tick();
    logic [31:0] w;
    bit dat, hs;
    hs = 1'b0;
    if (rst) begin
      m_cyc = 0; m_training = 1'b1; m_q.delete();
      m_cnt = 0; m_cnt2 = 0;
      e_data = 8'h00; e_frame = 1'b0; e_isdata = 1'b0;
    end else begin
      if (m_cyc % 4 == 3) begin
        dat = 1'b0;
        w = 32'h00000000;
        if (m_training) begin
          if (train) w = 32'hA55A6996;
          else m_training = 1'b0;
        end else if (train) begin
          m_training = 1'b1;
          w = 32'hA55A6996;
        end else if (if_a.s_tvalid) begin
          hs = 1'b1; dat = 1'b1; w = if_a.s_tdata;
        end
        for (int k = 0; k < 4; k++)
          m_q.push_back({w[31-8*k -: 8], (k == 0), dat});
      end
      if (clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (hs) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
        m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
      end
      if (m_q.size() > 0) {e_data, e_frame, e_isdata} = m_q.pop_front();
      else {e_data, e_frame, e_isdata} = 10'h000;
      m_cyc++;
    end
    last_hs = hs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; train = 1'b1; clr = 1'b0;
    if_a.s_tvalid = 1'b0; if_a.s_tdata = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (got !== 40'h0) begin
        n_err++;
        $display("FAIL reset: got %h need %h", got, 40'h0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_training();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (got !== exp_vec()) begin
        n_err++;
        $display("FAIL training cyc %0d: got %h need %h", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_idle();
    while (m_cyc % 4 != 1) tick();
    train = 1'b0;
    if_a.s_tvalid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_vec++;
      if (got !== exp_vec()) begin
        n_err++;
        $display("FAIL idle cyc %0d: got %h need %h", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    sent = 0;
    if_a.s_tvalid = 1'b1;
    if_a.s_tdata  = 32'h01020304;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (last_hs) begin
        sent++;
        if (sent == 1) if_a.s_tdata = 32'h11223344;
        else begin if_a.s_tvalid = 1'b0; if_a.s_tdata = $urandom; end
      end
      n_vec++;
      if (got !== exp_vec()) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: got %h need %h", i, got, exp_vec());
      end
    end
    n_vec++;
    if (cnt_a !== 16'd2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d need 2", cnt_a);
    end
  endtask

  task automatic test_train_preempt();
    if_a.s_tvalid = 1'b1;
    if_a.s_tdata  = $urandom;
    while (m_cyc % 4 != 3) tick();
    train = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 4) train = 1'b0;
      if (last_hs) begin if_a.s_tvalid = 1'b0; if_a.s_tdata = $urandom; end
      n_vec++;
      if (got !== exp_vec()) begin
        n_err++;
        $display("FAIL train_preempt cyc %0d: got %h need %h", i, got, exp_vec());
      end
    end
    n_vec++;
    if (cnt_a !== 16'd3) begin
      n_err++;
      $display("FAIL preempt_count: got %0d need 3", cnt_a);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] need[5];
    int hs_n;
    need[0] = 2'd1; need[1] = 2'd2; need[2] = 2'd3; need[3] = 2'd3; need[4] = 2'd0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    hs_n = 0;
    if_a.s_tvalid = 1'b1;
    if_a.s_tdata  = $urandom;
    for (int i = 0; i < 40 && hs_n < 5; i++) begin
      clr = (hs_n == 4 && m_cyc % 4 == 3) ? 1'b1 : 1'b0;
      tick();
      clr = 1'b0;
      n_vec++;
      if (got !== exp_vec()) begin
        n_err++;
        $display("FAIL saturation cyc %0d: got %h need %h", i, got, exp_vec());
      end
      if (last_hs) begin
        n_vec++;
        if (cnt_b !== need[hs_n]) begin
          n_err++;
          $display("FAIL sat_count word %0d: got %0d need %0d", hs_n, cnt_b, need[hs_n]);
        end
        hs_n++;
        if_a.s_tdata = $urandom;
      end
    end
    n_vec++;
    if (hs_n != 5) begin
      n_err++;
      $display("FAIL sat_handshakes: got %0d need 5", hs_n);
    end
    if_a.s_tvalid = 1'b0;
  endtask

  task automatic test_reset_midword();
    if_a.s_tvalid = 1'b1;
    if_a.s_tdata  = $urandom;
    for (int i = 0; i < 12 && !(e_isdata && m_cyc % 4 == 2); i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (got !== 40'h0) begin
      n_err++;
      $display("FAIL reset_midword: got %h need %h", got, 40'h0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_hs) if_a.s_tdata = $urandom;
      n_vec++;
      if (got !== exp_vec()) begin
        n_err++;
        $display("FAIL after_reset cyc %0d: got %h need %h", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) train = ~train;
      if_a.s_tvalid = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      if (last_hs) if_a.s_tdata = $urandom;
      n_vec++;
      if (got !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h need %h", i, got, exp_vec());
      end
    end
    rst = 1'b0; clr = 1'b0;
  endtask

  initial begin
    m_cyc = 0; m_training = 1'b1; m_cnt = 0; m_cnt2 = 0;
    e_data = 8'h00; e_frame = 1'b0; e_isdata = 1'b0; last_hs = 1'b0;
    test_reset();
    test_training();
    test_idle();
    test_back_to_back();
    test_train_preempt();
    test_saturation();
    test_reset_midword();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
